// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave front end for the SPI-to-RAM wrapper.
// Captures DATA_W+2 bit command frames from MOSI, hands them to the RAM as a
// one-cycle rx_valid pulse, and shifts RAM read data back out on MISO.
// Aborted frames raise frame_err; a missing tx_valid raises rd_timeout.
module spi_slave_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    output logic                MISO,
    output logic                frame_err,
    output logic                rd_timeout
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned TXC_W   = $clog2(DATA_W + 1);
    localparam int unsigned WAIT_W  = $clog2(TX_TIMEOUT + 1);

    if (DATA_W < 2) begin : g_bad_data_w
        $error("spi_slave_param: DATA_W must be at least 2");
    end
    if (TX_TIMEOUT < 1) begin : g_bad_timeout
        $error("spi_slave_param: TX_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // Sub-phase of READ_DATA once the command frame has been captured.
    typedef enum logic [1:0] {
        RD_WAIT,
        RD_SHIFT,
        RD_DONE
    } rd_phase_e;

    state_e               state_q,         state_d;
    rd_phase_e            rd_phase_q,      rd_phase_d;
    logic [CNT_W-1:0]     bit_cnt_q,       bit_cnt_d;
    logic [FRAME_W-2:0]   rx_sh_q,         rx_sh_d;
    logic [FRAME_W-1:0]   rx_data_q,       rx_data_d;
    logic                 rx_valid_q,      rx_valid_d;
    logic                 addr_data_sel_q, addr_data_sel_d;
    logic [WAIT_W-1:0]    wait_cnt_q,      wait_cnt_d;
    logic [DATA_W-1:0]    tx_sh_q,         tx_sh_d;
    logic [TXC_W-1:0]     tx_cnt_q,        tx_cnt_d;
    logic                 miso_q,          miso_d;
    logic                 frame_err_q,     frame_err_d;
    logic                 rd_timeout_q,    rd_timeout_d;

    logic                 capturing;
    logic                 frame_done;
    logic                 shifting_out;

    // Frame-progress flags shared by the abort and capture logic.
    always_comb begin
        frame_done   = (bit_cnt_q == CNT_W'(FRAME_W));
        capturing    = (state_q == WRITE) || (state_q == READ_ADD) ||
                       (state_q == READ_DATA);
        shifting_out = (state_q == READ_DATA) && frame_done &&
                       (rd_phase_q == RD_SHIFT);
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rd_phase_q      <= RD_WAIT;
            bit_cnt_q       <= '0;
            rx_sh_q         <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            addr_data_sel_q <= 1'b0;
            wait_cnt_q      <= '0;
            tx_sh_q         <= '0;
            tx_cnt_q        <= '0;
            miso_q          <= 1'b0;
            frame_err_q     <= 1'b0;
            rd_timeout_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_phase_q      <= rd_phase_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_sh_q         <= rx_sh_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            addr_data_sel_q <= addr_data_sel_d;
            wait_cnt_q      <= wait_cnt_d;
            tx_sh_q         <= tx_sh_d;
            tx_cnt_q        <= tx_cnt_d;
            miso_q          <= miso_d;
            frame_err_q     <= frame_err_d;
            rd_timeout_q    <= rd_timeout_d;
        end
    end

    // Next-state, frame capture and MISO read-out sequencing.
    always_comb begin
        state_d         = state_q;
        rd_phase_d      = rd_phase_q;
        bit_cnt_d       = bit_cnt_q;
        rx_sh_d         = rx_sh_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        addr_data_sel_d = addr_data_sel_q;
        wait_cnt_d      = wait_cnt_q;
        tx_sh_d         = tx_sh_q;
        tx_cnt_d        = tx_cnt_q;
        miso_d          = 1'b0;
        frame_err_d     = 1'b0;
        rd_timeout_d    = 1'b0;

        // Slave select released: abort has priority over everything, including
        // a last frame bit sampled on the same edge.
        if ((state_q != IDLE) && SS_n) begin
            state_d = IDLE;
            if ((state_q == CHK_CMD) || (capturing && !frame_done) || shifting_out) begin
                frame_err_d = 1'b1;
            end
            if (shifting_out) begin
                addr_data_sel_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!SS_n) begin
                        state_d = CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    bit_cnt_d  = '0;
                    rx_sh_d    = '0;
                    rd_phase_d = RD_WAIT;
                    wait_cnt_d = '0;
                    tx_cnt_d   = '0;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (addr_data_sel_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    if (!frame_done) begin
                        rx_sh_d   = {rx_sh_q[FRAME_W-3:0], MOSI};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            rx_data_d  = {rx_sh_q, MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD) begin
                                addr_data_sel_d = 1'b1;
                            end
                        end
                    end else if (state_q == READ_DATA) begin
                        unique case (rd_phase_q)
                            RD_WAIT: begin
                                // A tx_valid on the timeout edge still loads.
                                if (tx_valid) begin
                                    miso_d     = tx_data[DATA_W-1];
                                    tx_sh_d    = {tx_data[DATA_W-2:0], 1'b0};
                                    tx_cnt_d   = TXC_W'(1);
                                    rd_phase_d = RD_SHIFT;
                                end else if (wait_cnt_q == WAIT_W'(TX_TIMEOUT - 1)) begin
                                    rd_timeout_d    = 1'b1;
                                    addr_data_sel_d = 1'b0;
                                    rd_phase_d      = RD_DONE;
                                end else begin
                                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                                end
                            end
                            RD_SHIFT: begin
                                if (tx_cnt_q == TXC_W'(DATA_W)) begin
                                    addr_data_sel_d = 1'b0;
                                    rd_phase_d      = RD_DONE;
                                end else begin
                                    miso_d   = tx_sh_q[DATA_W-1];
                                    tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                                    tx_cnt_d = tx_cnt_q + TXC_W'(1);
                                end
                            end
                            default: begin
                                rd_phase_d = RD_DONE;
                            end
                        endcase
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign MISO       = miso_q;
    assign frame_err  = frame_err_q;
    assign rd_timeout = rd_timeout_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: scoreboard bench for spi_slave_param (DATA_W=8, TX_TIMEOUT=16).
module tb_spi_slave_param;

    localparam int DW = 8;
    localparam int FW = DW + 2;
    localparam int TO = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          SS_n     = 1'b1;
    logic          MOSI     = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic [FW-1:0] rx_data;
    logic          rx_valid;
    logic          MISO;
    logic          frame_err;
    logic          rd_timeout;

    int n_cmp  = 0;
    int n_bad  = 0;
    int fe_cnt = 0;
    int to_cnt = 0;
    int mh_cnt = 0;
    int fe0, to0, mh0;

    logic [FW-1:0] exp_q[$];
    logic [DW-1:0] pat;

    spi_slave_param #(
        .DATA_W    (DW),
        .TX_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .MISO      (MISO),
        .frame_err (frame_err),
        .rd_timeout(rd_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        fe0 = fe_cnt;
        to0 = to_cnt;
        mh0 = mh_cnt;
    endtask

    // Full frame: select edge, selector edge, FW data edges, then the drop edge.
    task automatic send_frame(input logic [FW-1:0] f, input logic sel);
        exp_q.push_back(f);
        SS_n = 1'b0;
        tick();
        MOSI = sel;
        tick();
        for (int i = FW - 1; i >= 0; i--) begin
            MOSI = f[i];
            tick();
        end
        check_eq("rx_valid_latency", 32'(rx_valid), 32'd1);
        tick();
        check_eq("rx_valid_drop", 32'(rx_valid), 32'd0);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        tick();
    endtask

    // Output monitor: pops the scoreboard on rx_valid, counts pulses and MISO highs.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) check_eq("rx_unexpected", 32'(rx_valid), 32'd0);
            else check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (frame_err) fe_cnt++;
        if (rd_timeout) to_cnt++;
        if (MISO) mh_cnt++;
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_miso", 32'(MISO), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_flags", {30'd0, frame_err, rd_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write frame
        snap();
        send_frame(10'h0A5, 1'b0);
        repeat (3) tick();
        end_frame();
        check_eq("wr_no_err", 32'(fe_cnt - fe0), 32'd0);
        check_eq("wr_miso_quiet", 32'(mh_cnt - mh0), 32'd0);

        // Read address then read data with tx_valid two edges later
        snap();
        send_frame(10'h203, 1'b1);
        tick();
        end_frame();
        send_frame(10'h300, 1'b1);
        pat = 8'hC3;
        tx_data = pat;
        tx_valid = 1'b1;
        tick();
        check_eq("miso_b7", 32'(MISO), 32'(pat[7]));
        tx_data = 8'h00;
        for (int i = 6; i >= 0; i--) begin
            tick();
            check_eq("miso_bit", 32'(MISO), 32'(pat[i]));
        end
        tick();
        check_eq("miso_after_lsb", 32'(MISO), 32'd0);
        tick();
        check_eq("miso_ignore_late_valid", 32'(MISO), 32'd0);
        tx_valid = 1'b0;
        end_frame();
        check_eq("rd_no_err", 32'(fe_cnt - fe0), 32'd0);
        check_eq("rd_miso_ones", 32'(mh_cnt - mh0), 32'd4);

        // Read-data selector without prior address: takes the READ_ADD path
        snap();
        send_frame(10'h3AB, 1'b1);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        repeat (4) tick();
        tx_valid = 1'b0;
        end_frame();
        check_eq("noaddr_miso_quiet", 32'(mh_cnt - mh0), 32'd0);

        // Timeout: 16 wait edges without tx_valid
        snap();
        send_frame(10'h355, 1'b1);
        repeat (14) tick();
        check_eq("to_not_early", 32'(rd_timeout), 32'd0);
        tick();
        check_eq("to_pulse", 32'(rd_timeout), 32'd1);
        check_eq("to_miso", 32'(MISO), 32'd0);
        tick();
        check_eq("to_drop", 32'(rd_timeout), 32'd0);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        repeat (4) tick();
        tx_valid = 1'b0;
        end_frame();
        check_eq("to_count", 32'(to_cnt - to0), 32'd1);
        check_eq("to_late_valid_ignored", 32'(mh_cnt - mh0), 32'd0);
        // Selector cleared by the timeout: next read frame is an address frame
        send_frame(10'h311, 1'b1);
        tx_valid = 1'b1;
        repeat (4) tick();
        tx_valid = 1'b0;
        end_frame();
        check_eq("to_sel_cleared", 32'(mh_cnt - mh0), 32'd0);

        // Abort after 5 payload bits of a write
        snap();
        SS_n = 1'b0;
        tick();
        MOSI = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0];
            tick();
        end
        SS_n = 1'b1;
        tick();
        check_eq("abort_err_pulse", 32'(frame_err), 32'd1);
        tick();
        check_eq("abort_err_drop", 32'(frame_err), 32'd0);
        check_eq("abort_err_count", 32'(fe_cnt - fe0), 32'd1);

        // Selector still set: READ_DATA, tx_valid exactly on the timeout edge
        snap();
        send_frame(10'h300, 1'b1);
        repeat (14) tick();
        pat = 8'h81;
        tx_data = pat;
        tx_valid = 1'b1;
        tick();
        check_eq("to_edge_load", 32'(MISO), 32'(pat[7]));
        check_eq("to_edge_no_timeout", 32'(rd_timeout), 32'd0);
        tx_valid = 1'b0;
        repeat (7) tick();
        check_eq("to_edge_lsb", 32'(MISO), 32'(pat[0]));
        end_frame();
        check_eq("to_edge_to_count", 32'(to_cnt - to0), 32'd0);

        // SS_n rises on the last frame bit edge: abort, no rx_valid
        snap();
        SS_n = 1'b0;
        tick();
        MOSI = 1'b0;
        tick();
        for (int i = 0; i < FW - 1; i++) begin
            MOSI = 1'b1;
            tick();
        end
        SS_n = 1'b1;
        tick();
        check_eq("lastbit_abort_err", 32'(frame_err), 32'd1);
        check_eq("lastbit_abort_no_rx", 32'(rx_valid), 32'd0);
        tick();

        // Reset during MISO read-out
        send_frame(10'h203, 1'b1);
        end_frame();
        send_frame(10'h3C0, 1'b1);
        pat = 8'hA5;
        tx_data = pat;
        tx_valid = 1'b1;
        tick();
        check_eq("rst_ro_b7", 32'(MISO), 32'(pat[7]));
        tx_valid = 1'b0;
        tick();
        check_eq("rst_ro_b6", 32'(MISO), 32'(pat[6]));
        tick();
        check_eq("rst_ro_b5", 32'(MISO), 32'(pat[5]));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_miso", 32'(MISO), 32'd0);
        check_eq("rst_async_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_async_rx_data", 32'(rx_data), 32'd0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        snap();
        send_frame(10'h2F0, 1'b1);
        tx_valid = 1'b1;
        repeat (4) tick();
        tx_valid = 1'b0;
        end_frame();
        check_eq("post_rst_addr_quiet", 32'(mh_cnt - mh0), 32'd0);
        check_eq("post_rst_no_err", 32'(fe_cnt - fe0), 32'd0);

        repeat (2) tick();
        check_eq("rx_missing", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
